// File: rtl/loader_pkg.sv
// loader_pkg: state encoding, default widths and checksum helper shared by the program loader files.
package loader_pkg;
   localparam int DEF_DATA_WIDTH = 8;
   localparam int DEF_ADDR_WIDTH = 4;
   localparam int DEF_DEPTH = 16;
   typedef enum logic [2:0] {IDLE, LOAD, WRITE, VREAD, VCMP, CHECK, DONE, ERROR} state_t;
   // Sum of two words reduced mod 2**w; callers size-cast the result to their word width.
   function automatic logic [31:0] csum(input logic [31:0] a, input logic [31:0] b, input int w);
      csum = (a + b) & ((32'd1 << w) - 32'd1);
   endfunction
endpackage

// File: rtl/program_loader_if.sv
// program_loader_if: host load stream, RAM port and status lines of the program loader.
interface program_loader_if import loader_pkg::*; #(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);
   logic programming, data_valid, ready, done_load, error, hold_cpu, ram_we, ram_re;
   logic [DATA_WIDTH-1:0] data_in, ram_wdata, ram_rdata;
   logic [ADDR_WIDTH-1:0] ram_addr;
   logic [ADDR_WIDTH:0] load_count;
   modport master (
      output programming, data_valid, data_in, ram_rdata,
      input  ready, done_load, error, hold_cpu, ram_addr, ram_wdata, ram_we, ram_re, load_count
   );
   modport slave (
      input  programming, data_valid, data_in, ram_rdata,
      output ready, done_load, error, hold_cpu, ram_addr, ram_wdata, ram_we, ram_re, load_count
   );
endinterface

// File: rtl/loader_checksum.sv
// loader_checksum: running mod-2**DATA_WIDTH sum of the image with a test for sum+data == 0.
module loader_checksum import loader_pkg::*; #(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_clr,
   input  logic                  i_add,
   input  logic [DATA_WIDTH-1:0] i_data,
   output logic                  o_zero
);
   logic [DATA_WIDTH-1:0] r_sum;
   always_ff @(posedge clk)
      if (rst || i_clr) r_sum <= '0;
      else if (i_add) r_sum <= DATA_WIDTH'(csum(32'(r_sum), 32'(i_data), DATA_WIDTH));
   assign o_zero = csum(32'(r_sum), 32'(i_data), DATA_WIDTH) == 32'd0;
endmodule

// File: rtl/program_loader.sv
// program_loader: streams a program image into RAM, optionally verifies each word, then checks the checksum byte.
module program_loader import loader_pkg::*; #(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int DEPTH      = DEF_DEPTH,
   parameter bit VERIFY_EN  = 1'b1
) (
   input logic             clk,
   input logic             rst,
   program_loader_if.slave bus
);
   state_t r_state, w_next;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [DATA_WIDTH-1:0] r_wbuf;
   logic w_accept, w_last, w_match, w_adv, w_zero;
   assign w_accept = (r_state == LOAD || r_state == CHECK) && bus.data_valid;
   assign w_last   = r_addr == ADDR_WIDTH'(DEPTH - 1);
   assign w_match  = bus.ram_rdata == r_wbuf;
   assign w_adv    = bus.programming && ((r_state == WRITE && !VERIFY_EN) || (r_state == VCMP && w_match));
   loader_checksum #(.DATA_WIDTH(DATA_WIDTH)) u_sum (
      .clk    (clk),
      .rst    (rst),
      .i_clr  (r_state == IDLE),
      .i_add  (r_state == LOAD && w_accept),
      .i_data (bus.data_in),
      .o_zero (w_zero)
   );
   // Dropping programming returns to IDLE from every state; DONE/ERROR otherwise hold.
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    w_next = LOAD;
         LOAD:    w_next = bus.data_valid ? WRITE : LOAD;
         WRITE:   w_next = VERIFY_EN ? VREAD : (w_last ? CHECK : LOAD);
         VREAD:   w_next = VCMP;
         VCMP:    w_next = !w_match ? ERROR : (w_last ? CHECK : LOAD);
         CHECK:   w_next = !bus.data_valid ? CHECK : (w_zero ? DONE : ERROR);
         default: w_next = r_state;
      endcase
      if (!bus.programming) w_next = IDLE;
   end
   // Outputs are registered as a decode of the state being entered.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state        <= IDLE;
         r_addr         <= '0;
         r_wbuf         <= '0;
         bus.ready      <= 1'b0;
         bus.done_load  <= 1'b0;
         bus.error      <= 1'b0;
         bus.hold_cpu   <= 1'b0;
         bus.ram_we     <= 1'b0;
         bus.ram_re     <= 1'b0;
         bus.ram_addr   <= '0;
         bus.ram_wdata  <= '0;
         bus.load_count <= '0;
      end else begin
         r_state        <= w_next;
         r_addr         <= r_state == IDLE ? '0 : r_addr + ADDR_WIDTH'(w_adv && !w_last);
         r_wbuf         <= (r_state == LOAD && w_accept) ? bus.data_in : r_wbuf;
         bus.ready      <= w_next == LOAD || w_next == CHECK;
         bus.done_load  <= w_next == DONE;
         bus.error      <= w_next == ERROR;
         bus.hold_cpu   <= !(w_next inside {IDLE, DONE});
         bus.ram_we     <= w_next == WRITE;
         bus.ram_re     <= w_next == VREAD;
         bus.ram_addr   <= (w_next == WRITE || w_next == VREAD) ? r_addr : '0;
         bus.ram_wdata  <= w_next == WRITE ? bus.data_in : '0;
         bus.load_count <= w_next == IDLE ? '0 : bus.load_count + (ADDR_WIDTH + 1)'(w_adv);
      end
   end
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: directed load scenarios against a verifying (16-word) and a write-only (4-word) loader.
module tb_program_loader;
   logic clk = 1'b0, rst = 1'b1, sel = 1'b0, prog_a = 1'b0, prog_b = 1'b0, dv = 1'b0;
   logic [7:0] din = 8'h00, rd_a = 8'h00, rd_b = 8'h00;
   logic [7:0] mem_a [16];
   logic [7:0] mem_b [4];
   logic [7:0] img [$];
   int corrupt = -1, m_wr = 0, n_re = 0, checks = 0, errors = 0;
   bit prev_we = 1'b0;

   always #5 clk = ~clk;

   program_loader_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) ia ();
   program_loader_if #(.DATA_WIDTH(8), .ADDR_WIDTH(2)) ib ();
   program_loader #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .DEPTH(16), .VERIFY_EN(1'b1)) dut_a (.clk(clk), .rst(rst), .bus(ia));
   program_loader #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .DEPTH(4), .VERIFY_EN(1'b0)) dut_b (.clk(clk), .rst(rst), .bus(ib));

   assign ia.programming = prog_a;
   assign ib.programming = prog_b;
   assign ia.data_valid  = dv;
   assign ib.data_valid  = dv;
   assign ia.data_in     = din;
   assign ib.data_in     = din;
   assign ia.ram_rdata   = rd_a;
   assign ib.ram_rdata   = rd_b;

   // RAM models; corrupt selects an address of dut_a whose read-back returns 0xFF.
   always @(posedge clk) begin
      if (ia.ram_we) mem_a[ia.ram_addr] <= ia.ram_wdata;
      if (ia.ram_re) rd_a <= (int'(ia.ram_addr) == corrupt) ? 8'hFF : mem_a[ia.ram_addr];
      if (ib.ram_we) mem_b[ib.ram_addr] <= ib.ram_wdata;
      if (ib.ram_re) rd_b <= mem_b[ib.ram_addr];
   end

   logic m_ready, m_done, m_err, m_hold, m_we, m_re, z_a, z_b;
   logic [3:0] m_addr;
   logic [7:0] m_wdata;
   logic [4:0] m_cnt;
   always_comb begin
      m_ready = sel ? ib.ready : ia.ready;
      m_done  = sel ? ib.done_load : ia.done_load;
      m_err   = sel ? ib.error : ia.error;
      m_hold  = sel ? ib.hold_cpu : ia.hold_cpu;
      m_we    = sel ? ib.ram_we : ia.ram_we;
      m_re    = sel ? ib.ram_re : ia.ram_re;
      m_addr  = sel ? {2'b00, ib.ram_addr} : ia.ram_addr;
      m_wdata = sel ? ib.ram_wdata : ia.ram_wdata;
      m_cnt   = sel ? {2'b00, ib.load_count} : ia.load_count;
      z_a = {ia.ready, ia.done_load, ia.error, ia.hold_cpu, ia.ram_we, ia.ram_re, ia.ram_addr, ia.ram_wdata, ia.load_count} == '0;
      z_b = {ib.ready, ib.done_load, ib.error, ib.hold_cpu, ib.ram_we, ib.ram_re, ib.ram_addr, ib.ram_wdata, ib.load_count} == '0;
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic int img_sum();
      int s = 0;
      foreach (img[i]) s += int'(img[i]);
      return s & 255;
   endfunction

   // Reference model: the k-th RAM write of a load must carry the k-th accepted word at address k.
   initial forever begin
      @(negedge clk);
      if (!rst) begin
         chk("other_idle", int'(sel ? z_a : z_b), 1);
         if (m_we && m_re) chk("we_re_exclusive", 1, 0);
         if (m_we) begin
            if (m_wr < img.size()) begin
               chk("wr_addr", int'(m_addr), m_wr);
               chk("wr_data", int'(m_wdata), int'(img[m_wr]));
            end else chk("unexpected_we", m_wr, img.size());
            m_wr++;
         end
         if (m_re) begin
            n_re++;
            chk("re_allowed", 1, sel ? 0 : 1);
            chk("re_addr", int'(m_addr), m_wr - 1);
            chk("re_after_we", int'(prev_we), 1);
         end
         if (m_done) begin
            chk("done_quiet", int'({m_err, m_hold, m_ready}), 0);
            chk("done_count", int'(m_cnt), sel ? 4 : 16);
         end
         if (m_err || m_ready || m_we || m_re) chk("hold_when_busy", int'(m_hold), 1);
         prev_we = m_we;
      end
   end

   task automatic start(input logic s);
      sel = s;
      img.delete();
      m_wr = 0;
      n_re = 0;
      if (s) prog_b = 1'b1;
      else prog_a = 1'b1;
   endtask

   task automatic send(input logic [7:0] d, input bit word, input int lat);
      int n = 0;
      while (!m_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("ready_before_send", int'(m_ready), 1);
      if (!m_ready) return;
      if (word) img.push_back(d);
      din = d;
      dv = 1'b1;
      @(posedge clk);
      #1 dv = 1'b0;
      if (lat > 0) begin
         n = 0;
         do begin
            @(negedge clk);
            n++;
         end while (!m_ready && n < 20);
         chk("ready_latency", n, lat);
      end
   endtask

   task automatic load_words(input int n, input int lat);
      for (int i = 1; i <= n; i++) send(8'(i), 1'b1, lat);
   endtask

   task automatic finish_load(input logic [7:0] cs, input int depth);
      bit pass;
      send(cs, 1'b0, 0);
      pass = ((img_sum() + int'(cs)) & 255) == 0;
      @(negedge clk);
      chk("done_load", int'(m_done), int'(pass));
      chk("error", int'(m_err), int'(!pass));
      chk("hold_cpu", int'(m_hold), int'(!pass));
      chk("load_count", int'(m_cnt), depth);
      chk("writes", m_wr, depth);
      repeat (3) @(negedge clk);
      chk("outcome_held", int'({m_done, m_err, m_hold}), pass ? 3'b100 : 3'b011);
   endtask

   task automatic release_prog();
      prog_a = 1'b0;
      prog_b = 1'b0;
      @(negedge clk);
      chk("idle_after_release", int'(sel ? z_b : z_a), 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("reset_a", int'(z_a), 1);
      chk("reset_b", int'(z_b), 1);

      // Clean 16-word load with read-back verify.
      start(1'b0);
      load_words(16, 4);
      chk("model_sum", img_sum(), 'h88);
      chk("ram_a_last", int'(mem_a[15]), 'h10);
      finish_load(8'h78, 16);
      release_prog();

      // Same image, wrong checksum byte.
      start(1'b0);
      load_words(16, 4);
      finish_load(8'h77, 16);
      release_prog();

      // Read-back of word 3 corrupted.
      corrupt = 3;
      start(1'b0);
      load_words(3, 4);
      send(8'h04, 1'b1, 0);
      repeat (4) @(negedge clk);
      chk("vcmp_error", int'({m_done, m_err, m_hold}), 3'b011);
      chk("vcmp_count", int'(m_cnt), 3);
      repeat (4) @(negedge clk);
      chk("vcmp_writes", m_wr, 4);
      release_prog();
      corrupt = -1;

      // Abort after five words.
      start(1'b0);
      load_words(5, 4);
      release_prog();
      repeat (5) @(negedge clk);
      chk("abort_writes", m_wr, 5);
      chk("abort_quiet", int'({m_done, m_err, m_cnt}), 0);

      // Write-only 4-word loader.
      start(1'b1);
      send(8'hAA, 1'b1, 2);
      send(8'h55, 1'b1, 2);
      send(8'h00, 1'b1, 2);
      send(8'h01, 1'b1, 2);
      chk("model_sum_b", img_sum(), 0);
      finish_load(8'h00, 4);
      chk("no_reads_b", n_re, 0);
      chk("ram_b_0", int'(mem_b[0]), 'hAA);
      chk("ram_b_3", int'(mem_b[3]), 'h01);
      release_prog();

      // Reset during the read-back of the first word, then a fresh load.
      start(1'b0);
      send(8'h11, 1'b1, 0);
      @(negedge clk);
      @(negedge clk);
      chk("rst_in_vread", int'(m_re), 1);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      prog_a = 1'b0;
      @(negedge clk);
      chk("rst_idle", int'(z_a), 1);
      start(1'b0);
      load_words(16, 4);
      finish_load(8'h78, 16);
      release_prog();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
